// File: rtl/switch_debounce_if.sv
// ---------------------------------------------------------------------------
// switch_debounce_if
//
// Purpose:
//   Internal bundle between the synchroniser front end and the debounce
//   qualification core of switch_debounce. It carries the synchronised raw
//   switch level into the core and the qualified level plus its edge pulses
//   back out.
//
// Signals:
//   sync_level     synchronised (metastability-filtered) switch level
//   level          debounced switch level
//   press_pulse    one-cycle pulse on an accepted 0->1 transition
//   release_pulse  one-cycle pulse on an accepted 1->0 transition
//
// Modports:
//   master  the debounce core: consumes sync_level, produces the outputs
//   slave   the surrounding logic: supplies sync_level, consumes the outputs
// ---------------------------------------------------------------------------
interface switch_debounce_if;
  logic sync_level;
  logic level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    input  sync_level,
    output level,
    output press_pulse,
    output release_pulse
  );

  modport slave (
    output sync_level,
    input  level,
    input  press_pulse,
    input  release_pulse
  );
endinterface : switch_debounce_if

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Purpose:
//   Conditions one raw mechanical push-button for the LED logic it feeds.
//   The asynchronous pin is brought into the i_Clk domain by a two-flop
//   synchroniser, then a four-state FSM with a qualification counter only
//   accepts a new level once it has been seen unchanged for
//   DEBOUNCE_CYCLES+1 consecutive cycles. Every output is registered, so
//   there is no combinational path from the pin to any output.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 2)
//   INIT_LEVEL       switch level assumed at reset
//
// Ports:
//   i_Clk            system clock
//   i_Rst            synchronous, active-high reset
//   i_Switch         raw asynchronous switch pin, active-high
//   o_Switch         debounced switch level
//   o_Press_Pulse    one-cycle pulse on accepted 0->1 transition
//   o_Release_Pulse  one-cycle pulse on accepted 1->0 transition
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// switch_debounce_sync: two-flop synchroniser, both stages reset to
// INIT_LEVEL so that reset never presents a fake edge to the core.
//   i_Clk, i_Rst  clock and synchronous active-high reset
//   i_async       raw asynchronous input
//   o_sync        synchronised level (second flop)
// ---------------------------------------------------------------------------
module switch_debounce_sync #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_async,
  output logic o_sync
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign o_sync = sync2_q;

endmodule : switch_debounce_sync

// ---------------------------------------------------------------------------
// switch_debounce_core: qualification FSM.
//   i_Clk, i_Rst  clock and synchronous active-high reset
//   bus           master side of switch_debounce_if (sync_level in,
//                 level / press_pulse / release_pulse out)
//
// A move out of a STABLE_* state is the first cycle of the new level; the
// CHECK_* state then needs DEBOUNCE_CYCLES more cycles of that level, so the
// total qualification is DEBOUNCE_CYCLES+1 consecutive cycles. Any cycle of
// the old level during CHECK_* returns to the old STABLE_* state silently.
// ---------------------------------------------------------------------------
module switch_debounce_core #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  switch_debounce_if.master  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } state_e;

  localparam state_e RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             level_d, level_q;
  logic             press_d, press_q;
  logic             release_d, release_q;

  // NOTE: every variable gets its default before the case statement; a path
  // that leaves one unassigned would infer a latch. Pulses default low, so
  // they can only ever last the single cycle that sets them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (bus.sync_level) begin
          state_d = CHECK_HI;
        end
      end

      CHECK_HI: begin
        if (!bus.sync_level) begin
          // Bounce back to the old level: discard the partial count.
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE_HI: begin
        cnt_d = '0;
        if (!bus.sync_level) begin
          state_d = CHECK_LO;
        end
      end

      CHECK_LO: begin
        if (bus.sync_level) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
        level_d = INIT_LEVEL;
      end
    endcase
  end

  // Synchronous reset wins over everything, including a qualification in
  // progress; it never raises a pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      level_q   <= INIT_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

  // Structural invariants of the qualification logic.
  a_pulse_exclusive : assert property (@(posedge i_Clk) disable iff (i_Rst)
    !(press_q && release_q));

  a_cnt_bound : assert property (@(posedge i_Clk) disable iff (i_Rst)
    cnt_q <= CNT_LAST);

  a_cnt_idle_zero : assert property (@(posedge i_Clk) disable iff (i_Rst)
    ((state_q == STABLE_LO) || (state_q == STABLE_HI)) |-> (cnt_q == '0));

endmodule : switch_debounce_core

// ---------------------------------------------------------------------------
// switch_debounce: top level, pin synchroniser plus qualification core.
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse
);

  switch_debounce_if db_if ();

  switch_debounce_sync #(
    .INIT_LEVEL (INIT_LEVEL)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_async (i_Switch),
    .o_sync  (db_if.sync_level)
  );

  switch_debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INIT_LEVEL      (INIT_LEVEL)
  ) u_core (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (db_if.master)
  );

  assign o_Switch        = db_if.level;
  assign o_Press_Pulse   = db_if.press_pulse;
  assign o_Release_Pulse = db_if.release_pulse;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce
//
// Two instances share clock, reset and switch pin: dut0 with INIT_LEVEL = 0
// and dut1 with INIT_LEVEL = 1, both with DEBOUNCE_CYCLES = 4. A run-length
// model (pin delayed two samples; a new level is taken once it has differed
// from the accepted level for DEBOUNCE_CYCLES+1 samples in a row) predicts
// every output of both instances and is compared on every falling edge.
// Directed scenarios add literal expectations on pulse counts and edge
// numbers that pin the model down.
// ---------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int         D    = 4;
  localparam logic [1:0] INIT = 2'b10;  // bit k = INIT_LEVEL of dut k

  logic clk;
  logic rst;
  logic sw;

  logic sw0, pr0, rl0;
  logic sw1, pr1, rl1;
  logic [1:0] dut_sw, dut_pr, dut_rl;

  assign dut_sw = {sw1, sw0};
  assign dut_pr = {pr1, pr0};
  assign dut_rl = {rl1, rl0};

  switch_debounce #(
    .DEBOUNCE_CYCLES (D),
    .INIT_LEVEL      (1'b0)
  ) dut0 (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_Switch        (sw),
    .o_Switch        (sw0),
    .o_Press_Pulse   (pr0),
    .o_Release_Pulse (rl0)
  );

  switch_debounce #(
    .DEBOUNCE_CYCLES (D),
    .INIT_LEVEL      (1'b1)
  ) dut1 (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_Switch        (sw),
    .o_Switch        (sw1),
    .o_Press_Pulse   (pr1),
    .o_Release_Pulse (rl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp,
               edge_cnt);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] dly [2];   // pin history, [1] is what the qualifier sees now
  logic [1:0] m_sw, m_pr, m_rl;
  int         run [2];   // consecutive samples differing from accepted level

  initial begin
    logic seen;
    forever begin
      @(posedge clk);
      edge_cnt++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          dly[k]  = {2{INIT[k]}};
          m_sw[k] = INIT[k];
          m_pr[k] = 1'b0;
          m_rl[k] = 1'b0;
          run[k]  = 0;
        end else begin
          seen    = dly[k][1];
          dly[k]  = {dly[k][0], sw};
          m_pr[k] = 1'b0;
          m_rl[k] = 1'b0;
          if (seen != m_sw[k]) begin
            run[k]++;
            if (run[k] == D + 1) begin
              m_sw[k] = seen;
              if (seen) m_pr[k] = 1'b1;
              else      m_rl[k] = 1'b1;
              run[k] = 0;
            end
          end else begin
            run[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and pulse statistics ----------------
  int pr_cnt [2];
  int rl_cnt [2];
  int last_pr_edge [2];
  int last_rl_edge [2];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("model_o_switch[%0d]", k), 32'(dut_sw[k]), 32'(m_sw[k]));
          check($sformatf("model_press[%0d]", k), 32'(dut_pr[k]), 32'(m_pr[k]));
          check($sformatf("model_release[%0d]", k), 32'(dut_rl[k]), 32'(m_rl[k]));
          if (dut_pr[k] === 1'b1) begin
            pr_cnt[k]++;
            last_pr_edge[k] = edge_cnt;
          end
          if (dut_rl[k] === 1'b1) begin
            rl_cnt[k]++;
            last_rl_edge[k] = edge_cnt;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 1 time unit after a falling edge, i.e. well clear of the
  // sampling rising edge; each call covers n rising edges.
  task automatic step(input logic v, input int n);
    repeat (n) begin
      sw = v;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      pr_cnt[k]       = 0;
      rl_cnt[k]       = 0;
      last_pr_edge[k] = -1;
      last_rl_edge[k] = -1;
    end
  endtask

  int s;
  int r;

  initial begin
    rst = 1'b1;
    sw  = 1'b0;
    clear_stats();
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    check("reset_o_switch0", 32'(sw0), 32'd0);
    check("reset_pulses0", 32'({pr0, rl0}), 32'd0);
    check("reset_o_switch1", 32'(sw1), 32'd1);

    // 1. Clean press: pulse after edge s+6, exactly one cycle wide.
    step(1'b0, 3);
    clear_stats();
    s = edge_cnt + 1;
    step(1'b1, 10);
    check("t1_press_count", 32'(pr_cnt[0]), 32'd1);
    check("t1_press_edge", 32'(last_pr_edge[0]), 32'(s + 6));
    check("t1_release_count", 32'(rl_cnt[0]), 32'd0);
    check("t1_o_switch", 32'(sw0), 32'd1);

    // 4. Release from accepted high: same latency, no press.
    clear_stats();
    s = edge_cnt + 1;
    step(1'b0, 10);
    check("t4_release_count", 32'(rl_cnt[0]), 32'd1);
    check("t4_release_edge", 32'(last_rl_edge[0]), 32'(s + 6));
    check("t4_press_count", 32'(pr_cnt[0]), 32'd0);
    check("t4_o_switch", 32'(sw0), 32'd0);

    // 2. Bounce: 4 high, 1 low, 2 high, 1 low, then steady high.
    clear_stats();
    step(1'b1, 4);
    step(1'b0, 1);
    step(1'b1, 2);
    step(1'b0, 1);
    s = edge_cnt + 1;
    step(1'b1, 12);
    check("t2_press_count", 32'(pr_cnt[0]), 32'd1);
    check("t2_press_edge", 32'(last_pr_edge[0]), 32'(s + 6));
    check("t2_release_count", 32'(rl_cnt[0]), 32'd0);
    step(1'b0, 10);

    // 3. Glitch reject: 4-cycle pulse changes nothing.
    clear_stats();
    step(1'b1, 4);
    step(1'b0, 12);
    check("t3_short_press", 32'(pr_cnt[0]), 32'd0);
    check("t3_short_release", 32'(rl_cnt[0]), 32'd0);
    check("t3_short_o_switch", 32'(sw0), 32'd0);

    // 3b. 5-cycle pulse is accepted: press then release.
    clear_stats();
    s = edge_cnt + 1;
    step(1'b1, 5);
    step(1'b0, 12);
    check("t3_long_press", 32'(pr_cnt[0]), 32'd1);
    check("t3_long_press_edge", 32'(last_pr_edge[0]), 32'(s + 6));
    check("t3_long_release", 32'(rl_cnt[0]), 32'd1);
    check("t3_long_release_edge", 32'(last_rl_edge[0]), 32'(s + 11));

    // 5. Reset while qualifying (counter at 2), pin held high throughout.
    clear_stats();
    step(1'b1, 5);
    sw = 1'b1;
    pulse_reset();
    r = edge_cnt;
    check("t5_reset_o_switch", 32'(sw0), 32'd0);
    step(1'b1, 12);
    check("t5_press_count", 32'(pr_cnt[0]), 32'd1);
    check("t5_press_edge", 32'(last_pr_edge[0]), 32'(r + 7));
    step(1'b0, 10);

    // 6. INIT_LEVEL = 1 instance with pin high through reset.
    sw = 1'b1;
    pulse_reset();
    check("t6_reset_o_switch1", 32'(sw1), 32'd1);
    clear_stats();
    step(1'b1, 20);
    check("t6_o_switch1", 32'(sw1), 32'd1);
    check("t6_press1", 32'(pr_cnt[1]), 32'd0);
    check("t6_release1", 32'(rl_cnt[1]), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_switch_debounce
